window_sched: RTL and testbench

- Turns the raster pixel stream into the nine 3×3 window taps that feed the filter operation stage.
- Tracks frame position and keeps two line buffers.
- Marks each window valid only when its centre pixel is interior to the frame.
- Sits between the pixel source and the filter stage; its outputs connect directly to the filter's d_00..d_22 inputs.

---
 rtl/window_sched_pkg.sv | 7 +
 rtl/window_sched_line_buf.sv | 16 +
 rtl/window_sched.sv | 84 ++++++++
 tb/tb_window_sched.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/window_sched_pkg.sv
// window_sched_pkg: shared state type and tap field widths for the 3x3 window scheduler
package window_sched_pkg;
  typedef enum logic {IDLE, RUN} state_t;
  localparam int PIX_W = 8;
  localparam int TAP_W = 9;
  localparam int VALID_BIT = 8;
endpackage

// File: rtl/window_sched_line_buf.sv
// line_buf: one line of pixels, combinational read and synchronous write on a shared address
module line_buf #(
  parameter int WIDTH = 640,
  parameter int CW = 10
) (
  input  logic          clk,
  input  logic          we,
  input  logic [CW-1:0] addr,
  input  logic [7:0]    wdata,
  output logic [7:0]    rdata
);
  logic [7:0] mem [WIDTH];
  assign rdata = mem[addr];
  always_ff @(posedge clk)
    if (we) mem[addr] <= wdata;
endmodule

// File: rtl/window_sched.sv
// window_sched: raster stream to 3x3 window taps; WINDOW_SCHED_ERRCNT_EN adds err_cnt for dropped/aborting pixels
module window_sched
  import window_sched_pkg::*;
#(
  parameter int WIDTH = 640,
  parameter int HEIGHT = 480,
  parameter int CW = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [TAP_W-1:0] pix_in,
  input  logic             sof,
  output logic [TAP_W-1:0] d_00,
  output logic [TAP_W-1:0] d_01,
  output logic [TAP_W-1:0] d_02,
  output logic [TAP_W-1:0] d_10,
  output logic [TAP_W-1:0] d_11,
  output logic [TAP_W-1:0] d_12,
  output logic [TAP_W-1:0] d_20,
  output logic [TAP_W-1:0] d_21,
  output logic [TAP_W-1:0] d_22,
  output logic             busy,
  output logic             frame_done
`ifdef WINDOW_SCHED_ERRCNT_EN
  ,
  output logic [15:0]      err_cnt
`endif
);
  state_t state;
  logic [CW-1:0] col, row, c, r;
  logic [2:0][2:0][PIX_W-1:0] w;
  logic wv, acc, last, eol;
  logic [PIX_W-1:0] top, mid, p;
  assign p = pix_in[PIX_W-1:0];
  assign acc = pix_in[VALID_BIT] && (state == RUN || sof);
  // sof restarts at (0,0) regardless of where the counters are
  assign c = sof ? '0 : col;
  assign r = sof ? '0 : row;
  assign eol = c == CW'(WIDTH - 1);
  assign last = eol && r == CW'(HEIGHT - 1);
  assign busy = state == RUN;
  line_buf #(.WIDTH(WIDTH), .CW(CW)) u_lb0 (.clk(clk), .we(acc), .addr(c), .wdata(p), .rdata(mid));
  line_buf #(.WIDTH(WIDTH), .CW(CW)) u_lb1 (.clk(clk), .we(acc), .addr(c), .wdata(mid), .rdata(top));
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      col <= '0;
      row <= '0;
      wv <= 1'b0;
      frame_done <= 1'b0;
      w <= '0;
    end else begin
      wv <= acc && r >= CW'(2) && c >= CW'(2);
      frame_done <= acc && last;
      if (acc) begin
        state <= last ? IDLE : RUN;
        col <= (last || eol) ? '0 : c + 1'b1;
        row <= last ? '0 : eol ? r + 1'b1 : r;
        for (int i = 0; i < 3; i++) begin
          w[i][0] <= w[i][1];
          w[i][1] <= w[i][2];
        end
        w[0][2] <= top;
        w[1][2] <= mid;
        w[2][2] <= p;
      end
    end
  end
  assign d_00 = {wv, w[0][0]};
  assign d_01 = {wv, w[0][1]};
  assign d_02 = {wv, w[0][2]};
  assign d_10 = {wv, w[1][0]};
  assign d_11 = {wv, w[1][1]};
  assign d_12 = {wv, w[1][2]};
  assign d_20 = {wv, w[2][0]};
  assign d_21 = {wv, w[2][1]};
  assign d_22 = {wv, w[2][2]};
`ifdef WINDOW_SCHED_ERRCNT_EN
  // in IDLE a pixel without sof is dropped; in RUN a sof aborts the frame
  always_ff @(posedge clk)
    if (rst) err_cnt <= '0;
    else if (pix_in[VALID_BIT] && (state == RUN ? sof : !sof) && err_cnt != '1) err_cnt <= err_cnt + 1'b1;
`endif
endmodule

// File: tb/tb_window_sched.sv
// tb_window_sched: randomized frames checked against an image-array reference model
module tb_window_sched;
  localparam int W = 4, H = 3;
  logic clk = 0, rst = 1, sof = 0;
  logic [8:0] pix_in = '0;
  logic [8:0] d_00, d_01, d_02, d_10, d_11, d_12, d_20, d_21, d_22;
  logic busy, frame_done;
`ifdef WINDOW_SCHED_ERRCNT_EN
  logic [15:0] err_cnt;
`endif
  always #5 clk = ~clk;
  window_sched #(.WIDTH(W), .HEIGHT(H), .CW(2)) dut (
    .clk(clk), .rst(rst), .pix_in(pix_in), .sof(sof),
    .d_00(d_00), .d_01(d_01), .d_02(d_02), .d_10(d_10), .d_11(d_11), .d_12(d_12),
    .d_20(d_20), .d_21(d_21), .d_22(d_22), .busy(busy), .frame_done(frame_done)
`ifdef WINDOW_SCHED_ERRCNT_EN
    , .err_cnt(err_cnt)
`endif
  );
  wire [71:0] win = {d_00[7:0], d_01[7:0], d_02[7:0], d_10[7:0], d_11[7:0], d_12[7:0], d_20[7:0], d_21[7:0], d_22[7:0]};
  wire [8:0] vbits = {d_00[8], d_01[8], d_02[8], d_10[8], d_11[8], d_12[8], d_20[8], d_21[8], d_22[8]};
  typedef struct {bit v; bit s; logic [7:0] p;} stim_t;
  stim_t q[$];
  logic [71:0] caps[$];
  int checks = 0, errors = 0;
  logic [7:0] img [H][W];
  bit m_run = 0, exp_v, exp_done;
  int m_r = 0, m_c = 0, m_err = 0, nwin = 0, ndone = 0;
  logic [71:0] exp_win = '0;
  task automatic add_pix(input bit s, input logic [7:0] p, input int gap_pct);
    while ($urandom_range(99) < gap_pct) q.push_back('{v: 0, s: 1'($urandom), p: 8'($urandom)});
    q.push_back('{v: 1, s: s, p: p});
  endtask
  task automatic add_frame(input int base, input int gap_pct);
    for (int rr = 0; rr < H; rr++)
      for (int cc = 0; cc < W; cc++) add_pix(rr == 0 && cc == 0, 8'(base + 10 * rr + cc), gap_pct);
  endtask
  // model: frame image plus raster position; window taken straight from the image
  task automatic feed(input bit v, input bit s, input logic [7:0] p);
    pix_in = {v, p};
    sof = s;
    exp_v = 0;
    exp_done = 0;
    if (v && (m_run || s)) begin
      if (s) begin
        if (m_run) m_err++;
        m_r = 0;
        m_c = 0;
      end
      img[m_r][m_c] = p;
      exp_v = m_r >= 2 && m_c >= 2;
      if (exp_v)
        for (int rr = 0; rr < 3; rr++)
          for (int cc = 0; cc < 3; cc++) exp_win[71 - 8 * (3 * rr + cc) -: 8] = img[m_r - 2 + rr][m_c - 2 + cc];
      exp_done = m_r == H - 1 && m_c == W - 1;
      m_run = !exp_done;
      if (m_c == W - 1) begin
        m_c = 0;
        m_r = exp_done ? 0 : m_r + 1;
      end else m_c++;
    end else if (v) m_err++;
    @(posedge clk);
    #1;
    nwin += int'(exp_v);
    ndone += int'(frame_done);
    if (exp_v) caps.push_back(win);
  endtask
  task automatic test_reset;
    checks++;
    if (win !== '0 || vbits !== '0 || busy !== 0 || frame_done !== 0) begin
      errors++;
      $display("FAIL reset: win=%h v=%b busy=%b done=%b, want all 0", win, vbits, busy, frame_done);
    end
`ifdef WINDOW_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL reset_errcnt: got %0d want 0", err_cnt); end
`endif
  endtask
  task automatic test_full_frame;
    q.delete(); caps.delete(); nwin = 0; ndone = 0;
    add_frame(0, 0);
    foreach (q[i]) begin
      feed(q[i].v, q[i].s, q[i].p);
      checks++;
      if (vbits !== {9{exp_v}} || (exp_v && win !== exp_win) || frame_done !== exp_done || busy !== m_run) begin
        errors++;
        $display("FAIL full_frame step %0d: v=%b win=%h done=%b busy=%b want v=%b win=%h done=%b busy=%b", i, vbits, win, frame_done, busy, exp_v, exp_win, exp_done, m_run);
      end
    end
    checks++;
    if (nwin != 2 || ndone != 1 || caps.size() != 2) begin
      errors++;
      $display("FAIL full_frame_count: windows %0d done %0d, want 2 and 1", nwin, ndone);
    end else begin
      checks++;
      if (caps[0] !== 72'h000102_0a0b0c_141516 || caps[1] !== 72'h010203_0b0c0d_151617) begin
        errors++;
        $display("FAIL full_frame_taps: got %h %h want 0001020a0b0c141516 0102030b0c0d151617", caps[0], caps[1]);
      end
    end
  endtask
  task automatic test_gaps;
    for (int k = 0; k < 3; k++) begin
      q.delete(); nwin = 0; ndone = 0;
      add_frame($urandom_range(100), 40);
      q.push_back('{v: 0, s: 0, p: 8'($urandom)});
      foreach (q[i]) begin
        feed(q[i].v, q[i].s, q[i].p);
        checks++;
        if (vbits !== {9{exp_v}} || (exp_v && win !== exp_win) || frame_done !== exp_done || busy !== m_run) begin
          errors++;
          $display("FAIL gaps step %0d: v=%b win=%h done=%b busy=%b want v=%b win=%h done=%b busy=%b", i, vbits, win, frame_done, busy, exp_v, exp_win, exp_done, m_run);
        end
      end
      checks++;
      if (nwin != 2 || ndone != 1) begin errors++; $display("FAIL gaps_count: windows %0d done %0d, want 2 and 1", nwin, ndone); end
    end
  endtask
  task automatic test_no_sof;
    int e0 = m_err;
    q.delete(); nwin = 0;
    for (int k = 0; k < 10; k++) add_pix(0, 8'($urandom), 30);
    foreach (q[i]) begin
      feed(q[i].v, q[i].s, q[i].p);
      checks++;
      if (vbits !== '0 || busy !== 0 || frame_done !== 0) begin
        errors++;
        $display("FAIL no_sof step %0d: v=%b busy=%b done=%b want 0", i, vbits, busy, frame_done);
      end
    end
    checks++;
    if (m_err - e0 != 10) begin errors++; $display("FAIL no_sof_model: dropped %0d want 10", m_err - e0); end
`ifdef WINDOW_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL no_sof_errcnt: got %0d want %0d", err_cnt, m_err); end
`endif
  endtask
  task automatic test_abort;
    q.delete(); nwin = 0; ndone = 0;
    for (int k = 0; k < 6; k++) add_pix(k == 0, 8'(200 + k), 20);
    add_frame(50, 20);
    foreach (q[i]) begin
      feed(q[i].v, q[i].s, q[i].p);
      checks++;
      if (vbits !== {9{exp_v}} || (exp_v && win !== exp_win) || frame_done !== exp_done || busy !== m_run) begin
        errors++;
        $display("FAIL abort step %0d: v=%b win=%h done=%b busy=%b want v=%b win=%h done=%b busy=%b", i, vbits, win, frame_done, busy, exp_v, exp_win, exp_done, m_run);
      end
    end
    checks++;
    if (nwin != 2 || ndone != 1) begin errors++; $display("FAIL abort_count: windows %0d done %0d, want 2 and 1", nwin, ndone); end
`ifdef WINDOW_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 16'(m_err)) begin errors++; $display("FAIL abort_errcnt: got %0d want %0d", err_cnt, m_err); end
`endif
  endtask
  task automatic test_mid_reset;
    q.delete();
    add_frame(90, 0);
    for (int i = 0; i < 2 * W + 2; i++) feed(q[i].v, q[i].s, q[i].p);
    pix_in = {1'b1, 8'hff};
    sof = 0;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    m_run = 0; m_r = 0; m_c = 0; m_err = 0;
    checks++;
    if (win !== '0 || vbits !== '0 || busy !== 0 || frame_done !== 0) begin
      errors++;
      $display("FAIL mid_reset: win=%h v=%b busy=%b done=%b, want all 0", win, vbits, busy, frame_done);
    end
`ifdef WINDOW_SCHED_ERRCNT_EN
    checks++;
    if (err_cnt !== 0) begin errors++; $display("FAIL mid_reset_errcnt: got %0d want 0", err_cnt); end
`endif
    q.delete(); nwin = 0; ndone = 0;
    add_frame(30, 25);
    foreach (q[i]) begin
      feed(q[i].v, q[i].s, q[i].p);
      checks++;
      if (vbits !== {9{exp_v}} || (exp_v && win !== exp_win) || frame_done !== exp_done || busy !== m_run) begin
        errors++;
        $display("FAIL after_reset step %0d: v=%b win=%h done=%b busy=%b want v=%b win=%h done=%b busy=%b", i, vbits, win, frame_done, busy, exp_v, exp_win, exp_done, m_run);
      end
    end
    checks++;
    if (nwin != 2 || ndone != 1) begin errors++; $display("FAIL after_reset_count: windows %0d done %0d, want 2 and 1", nwin, ndone); end
  endtask
  task automatic test_back_to_back;
    q.delete(); nwin = 0; ndone = 0;
    add_frame(0, 0);
    add_frame(100, 0);
    foreach (q[i]) begin
      feed(q[i].v, q[i].s, q[i].p);
      checks++;
      if (vbits !== {9{exp_v}} || (exp_v && win !== exp_win) || frame_done !== exp_done || busy !== m_run) begin
        errors++;
        $display("FAIL back_to_back step %0d: v=%b win=%h done=%b busy=%b want v=%b win=%h done=%b busy=%b", i, vbits, win, frame_done, busy, exp_v, exp_win, exp_done, m_run);
      end
    end
    checks++;
    if (nwin != 4 || ndone != 2) begin errors++; $display("FAIL back_to_back_count: windows %0d done %0d, want 4 and 2", nwin, ndone); end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    rst = 0;
    test_full_frame();
    test_gaps();
    test_no_sof();
    test_abort();
    test_mid_reset();
    test_back_to_back();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
